// File: rtl/hex_seg_decoder.sv
// Registered hex-to-7-segment cathode decoder with blank and lamp-test controls.
// Segment order on cathode is {g,f,e,d,c,b,a}; polarity is set by ACTIVE_LOW.
module hex_seg_decoder #(
  parameter int ACTIVE_LOW = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] four_bit_number,
  input  logic       blank,
  input  logic       lamp_test,
  output logic [6:0] cathode
);

  localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic [6:0] w_pattern;
  logic [6:0] w_drive;
  logic [6:0] r_cathode;

  // NOTE: w_pattern gets a default before the if/case so no path leaves it unassigned (no latch).
  always_comb begin
    w_pattern = 7'h00;
    if (blank) begin
      w_pattern = 7'h00;
    end else if (lamp_test) begin
      w_pattern = 7'h7F;
    end else begin
      case (four_bit_number)
        4'h0:    w_pattern = 7'h3F;
        4'h1:    w_pattern = 7'h06;
        4'h2:    w_pattern = 7'h5B;
        4'h3:    w_pattern = 7'h4F;
        4'h4:    w_pattern = 7'h66;
        4'h5:    w_pattern = 7'h6D;
        4'h6:    w_pattern = 7'h7D;
        4'h7:    w_pattern = 7'h07;
        4'h8:    w_pattern = 7'h7F;
        4'h9:    w_pattern = 7'h6F;
        4'hA:    w_pattern = 7'h77;
        4'hB:    w_pattern = 7'h7C;
        4'hC:    w_pattern = 7'h39;
        4'hD:    w_pattern = 7'h5E;
        4'hE:    w_pattern = 7'h79;
        default: w_pattern = 7'h71;
      endcase
    end
  end

  assign w_drive = (ACTIVE_LOW != 0) ? ~w_pattern : w_pattern;

  // NOTE: non-blocking assignment for registered state; reset blanks the display asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cathode <= SEG_OFF;
    end else begin
      r_cathode <= w_drive;
    end
  end

  assign cathode = r_cathode;

endmodule

// File: tb/tb_hex_seg_decoder.sv
// Directed bench for hex_seg_decoder: both polarities driven from shared inputs,
// checked against hand-derived cathode tables one cycle after each input edge.
module tb_hex_seg_decoder;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] four_bit_number = 4'h0;
  logic       blank = 1'b0;
  logic       lamp_test = 1'b0;
  logic [6:0] cathode_lo;
  logic [6:0] cathode_hi;

  int checks = 0;
  int failures = 0;

  // Active-low cathode per digit and the raw active-high segment pattern.
  logic [6:0] exp_lo [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0] exp_hi [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clock = ~clock;

  hex_seg_decoder #(.ACTIVE_LOW(1)) u_dut_lo (
    .clock(clock), .reset(reset), .four_bit_number(four_bit_number),
    .blank(blank), .lamp_test(lamp_test), .cathode(cathode_lo)
  );

  hex_seg_decoder #(.ACTIVE_LOW(0)) u_dut_hi (
    .clock(clock), .reset(reset), .four_bit_number(four_bit_number),
    .blank(blank), .lamp_test(lamp_test), .cathode(cathode_hi)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    four_bit_number = 4'h8;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (cathode_lo !== 7'h7F) begin
      failures++;
      $display("FAIL reset_async_lo: got %h want 7f", cathode_lo);
    end
    checks++;
    if (cathode_hi !== 7'h00) begin
      failures++;
      $display("FAIL reset_async_hi: got %h want 00", cathode_hi);
    end
    repeat (3) tick();
    checks++;
    if (cathode_lo !== 7'h7F) begin
      failures++;
      $display("FAIL reset_hold_lo: got %h want 7f", cathode_lo);
    end
    reset = 1'b0;
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 16; i++) begin
      four_bit_number = 4'(i);
      if (i > 0) begin
        #1;
        checks++;
        if (cathode_lo !== exp_lo[i-1]) begin
          failures++;
          $display("FAIL sweep_pre_edge[%0d]: got %h want %h", i, cathode_lo, exp_lo[i-1]);
        end
      end
      tick();
      checks++;
      if (cathode_lo !== exp_lo[i]) begin
        failures++;
        $display("FAIL sweep_lo[%0d]: got %h want %h", i, cathode_lo, exp_lo[i]);
      end
      checks++;
      if (cathode_hi !== exp_hi[i]) begin
        failures++;
        $display("FAIL sweep_hi[%0d]: got %h want %h", i, cathode_hi, exp_hi[i]);
      end
    end
  endtask

  task automatic test_blank_priority();
    logic [6:0] want_lo [3] = '{7'h7F, 7'h00, 7'h00};
    logic [6:0] want_hi [3] = '{7'h00, 7'h7F, 7'h7F};
    four_bit_number = 4'h8;
    for (int step = 0; step < 3; step++) begin
      blank     = (step == 0);
      lamp_test = (step < 2);
      tick();
      checks++;
      if (cathode_lo !== want_lo[step] || cathode_hi !== want_hi[step]) begin
        failures++;
        $display("FAIL blank_priority[%0d]: got lo=%h hi=%h want lo=%h hi=%h",
                 step, cathode_lo, cathode_hi, want_lo[step], want_hi[step]);
      end
    end
  endtask

  task automatic test_polarity();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (cathode_hi !== 7'h00) begin
      failures++;
      $display("FAIL polarity_reset: got %h want 00", cathode_hi);
    end
    #2 reset = 1'b0;
    tick();
    four_bit_number = 4'h0;
    tick();
    checks++;
    if (cathode_hi !== 7'h3F) begin
      failures++;
      $display("FAIL polarity_digit0: got %h want 3f", cathode_hi);
    end
    four_bit_number = 4'hA;
    tick();
    checks++;
    if (cathode_hi !== 7'h77) begin
      failures++;
      $display("FAIL polarity_digitA: got %h want 77", cathode_hi);
    end
    lamp_test = 1'b1;
    tick();
    checks++;
    if (cathode_hi !== 7'h7F) begin
      failures++;
      $display("FAIL polarity_lamp: got %h want 7f", cathode_hi);
    end
    lamp_test = 1'b0;
  endtask

  task automatic test_midstream_reset();
    four_bit_number = 4'h1;
    tick();
    checks++;
    if (cathode_lo !== 7'h79) begin
      failures++;
      $display("FAIL midreset_d1: got %h want 79", cathode_lo);
    end
    four_bit_number = 4'h2;
    tick();
    checks++;
    if (cathode_lo !== 7'h24) begin
      failures++;
      $display("FAIL midreset_d2: got %h want 24", cathode_lo);
    end
    four_bit_number = 4'h3;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (cathode_lo !== 7'h7F || cathode_hi !== 7'h00) begin
      failures++;
      $display("FAIL midreset_async: got lo=%h hi=%h want lo=7f hi=00", cathode_lo, cathode_hi);
    end
    #2 reset = 1'b0;
    four_bit_number = 4'h5;
    #1;
    checks++;
    if (cathode_lo !== 7'h7F) begin
      failures++;
      $display("FAIL midreset_release_hold: got %h want 7f", cathode_lo);
    end
    tick();
    checks++;
    if (cathode_lo !== 7'h12) begin
      failures++;
      $display("FAIL midreset_resume: got %h want 12", cathode_lo);
    end
  endtask

  task automatic test_back_to_back_scan();
    logic [31:0] frame = 32'h89ABCDEF;
    logic [6:0]  want [8] = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
    for (int slot = 0; slot < 8; slot++) begin
      four_bit_number = frame[slot*4 +: 4];
      tick();
      checks++;
      if (cathode_lo !== want[slot]) begin
        failures++;
        $display("FAIL scan_slot[%0d]: got %h want %h", slot, cathode_lo, want[slot]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_blank_priority();
    blank     = 1'b0;
    lamp_test = 1'b0;
    test_polarity();
    test_midstream_reset();
    test_back_to_back_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_seg_decoder.md
Name: hex_seg_decoder

Overview:
Registered 4-bit hexadecimal to 7-segment cathode decoder for the multiplexed 8-digit display driver. The scan FSM presents one nibble per refresh slot, and this block returns the matching cathode pattern. It sits between the digit-scan FSM and the board cathode pins. It adds blanking and lamp-test controls.

Parameters:
ACTIVE_LOW, 1, 1 = a lit segment drives its cathode bit to 0 (board default); 0 = a lit segment drives 1.

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
four_bit_number  input  4  hex digit to display, 0x0..0xF
blank  input  1  1 = all segments off
lamp_test  input  1  1 = all segments on
cathode  output  7  segment drive, registered; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g

Behaviour:
- Clocking and reset:
  - One clock domain.
  - reset is asynchronous and active-high.
  - While reset=1, cathode = all segments off: 7'h7F when ACTIVE_LOW=1, 7'h00 when ACTIVE_LOW=0.
  - The first rising edge after reset deassertion loads a decoded value.
- Latency:
  - cathode is registered.
  - Inputs sampled on rising edge N appear on cathode immediately after edge N.
  - Latency is exactly 1 clock.
  - No combinational path from inputs to cathode.
- Priority, highest first: reset > blank > lamp_test > four_bit_number decode.
  - blank=1: segment pattern 7'b0000000 (all off).
  - lamp_test=1 with blank=0: pattern 7'b1111111 (all on).
- Decode table, active-high segment pattern {g,f,e,d,c,b,a} in hex:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
  - Letters render as A, b, C, d, E, F.
- Output polarity:
  - ACTIVE_LOW=1: cathode = bitwise inverse of the pattern (e.g. 0 -> 7'h40, 8 -> 7'h00).
  - ACTIVE_LOW=0: cathode = the pattern unchanged.
- Every 4-bit input value is legal; no X or unspecified outputs.
- All 16 codes plus blank and lamp_test are fully decoded.
- Input changes every cycle are supported; each cycle's input maps independently, with no hold-off.
- Reset asserted mid-operation forces all segments off immediately, without waiting for a clock edge.
  - Decoding resumes on the first edge after release.
  - No history is retained.

Test Plan:
1. Reset: assert reset with four_bit_number=0x8 -> cathode=7'h7F immediately, no clock edge needed; it stays 7'h7F while reset=1.
2. Full sweep (ACTIVE_LOW=1): drive 0x0..0xF on consecutive edges -> one cycle later cathode = 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex). Each value lands exactly one edge after it is applied.
3. Blank priority: four_bit_number=0x8, lamp_test=1, blank=1 -> cathode=7'h7F. Drop blank -> next edge cathode=7'h00. Drop lamp_test -> next edge cathode=7'h00 (digit 8).
4. Polarity (ACTIVE_LOW=0): reset -> 7'h00. Input 0x0 -> 7'h3F. Input 0xA -> 7'h77. Lamp test -> 7'h7F.
5. Mid-stream reset: stream 0x1,0x2,0x3, asserting reset between edges -> cathode=7'h7F asynchronously. Release, then apply 0x5 -> cathode=7'h12 after one edge.
6. Scan integration: drive nibbles of 32'h89ABCDEF in slot order 0..7 -> cathode sequence 0E,06,21,46,03,08,10,00 (hex).
